fetch_redirect_unit: RTL

- Consumes the branch controller's per-cycle decision (mux_controller, imm_control, valid_previous, valid_next2) for the dual-issue ID/RF pair.
- Owns the fetch PC register and the IF/ID slot valid bits.
- Computes and applies redirect targets, buffering a redirect across instruction-memory stalls.
- Sits between ID/RF-stage branch resolution and the IF stage. Also exports kill for ID/RF slot 2 and a redirect performance counter.

---
 rtl/fetch_redirect_unit_if.sv | 42 ++++
 rtl/fetch_redirect_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit_if.sv
// Decision/fetch bus between the ID/RF branch controller, the IF stage and the
// fetch redirect unit. The redirect unit connects through the slave modport.
interface fetch_redirect_unit_if #(
  parameter int CNT_W = 16
);
  logic             fetch_ready;
  logic             Valid1_out_ID_RF;
  logic             Valid2_out_ID_RF;
  logic [1:0]       mux_controller;
  logic [1:0]       imm_control;
  logic             valid_previous;
  logic             valid_next2;
  logic [15:0]      pc_1_ID_RF;
  logic [15:0]      pc_2_ID_RF;
  logic [15:0]      imm_1_ID_RF;
  logic [15:0]      imm_2_ID_RF;
  logic [15:0]      RB_read1;
  logic [15:0]      RB_read2;
  logic [15:0]      pc_IF;
  logic             Valid1_IF_ID;
  logic             Valid2_IF_ID;
  logic             kill2_ID_RF;
  logic             redirect_taken;
  logic [CNT_W-1:0] redirect_count;
  logic             protocol_err;

  modport slave (
    input  fetch_ready, Valid1_out_ID_RF, Valid2_out_ID_RF, mux_controller,
           imm_control, valid_previous, valid_next2, pc_1_ID_RF, pc_2_ID_RF,
           imm_1_ID_RF, imm_2_ID_RF, RB_read1, RB_read2,
    output pc_IF, Valid1_IF_ID, Valid2_IF_ID, kill2_ID_RF, redirect_taken,
           redirect_count, protocol_err
  );

  modport master (
    output fetch_ready, Valid1_out_ID_RF, Valid2_out_ID_RF, mux_controller,
           imm_control, valid_previous, valid_next2, pc_1_ID_RF, pc_2_ID_RF,
           imm_1_ID_RF, imm_2_ID_RF, RB_read1, RB_read2,
    input  pc_IF, Valid1_IF_ID, Valid2_IF_ID, kill2_ID_RF, redirect_taken,
           redirect_count, protocol_err
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner for the dual-issue front end: applies branch-controller
// redirects, holds a redirect across imem stalls and squashes IF/ID slots.
module fetch_redirect_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  fetch_redirect_unit_if.slave   bus
);

  typedef enum logic {RUN, PEND} state_e;

  state_e           state, state_nxt;
  logic [15:0]      pc, pc_nxt;
  logic [15:0]      pend_target, pend_nxt;
  logic             vld, vld_nxt;
  logic             pulse, pulse_nxt;
  logic             err, err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             q, redir, seq_sel;
  logic [15:0]      target;

  function automatic logic [15:0] decode_target(
    input logic [1:0]  mux,
    input logic [1:0]  imm_sel,
    input logic [15:0] pc1, input logic [15:0] imm1,
    input logic [15:0] pc2, input logic [15:0] imm2,
    input logic [15:0] rb1, input logic [15:0] rb2
  );
    logic [15:0] t;
    t = 16'h0000;
    case (mux)
      2'b00: t = rb1;
      2'b10: t = rb2;
      2'b01: begin
        case (imm_sel)
          2'b00, 2'b01: t = pc1 + imm1;
          default:      t = pc2 + imm2;
        endcase
      end
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Decision qualification: only a fully valid ID/RF pair may redirect or squash
  assign q       = bus.Valid1_out_ID_RF & bus.Valid2_out_ID_RF;
  assign seq_sel = (bus.mux_controller == 2'b11);
  assign redir   = q & ~seq_sel;
  assign target  = decode_target(bus.mux_controller, bus.imm_control,
                                 bus.pc_1_ID_RF, bus.imm_1_ID_RF,
                                 bus.pc_2_ID_RF, bus.imm_2_ID_RF,
                                 bus.RB_read1, bus.RB_read2);

  assign bus.kill2_ID_RF = q & ~bus.valid_next2;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    pend_nxt  = pend_target;
    vld_nxt   = 1'b0;
    pulse_nxt = 1'b0;
    cnt_nxt   = cnt;
    err_nxt   = err | (q & (seq_sel != bus.valid_previous));
    case (state)
      RUN: begin
        if (redir) begin
          pulse_nxt = 1'b1;
          cnt_nxt   = sat_inc(cnt);
          if (bus.fetch_ready) begin
            pc_nxt = target;
          end else begin
            pend_nxt  = target;
            state_nxt = PEND;
          end
        end else if (bus.fetch_ready) begin
          pc_nxt  = pc + 16'd2;
          vld_nxt = bus.valid_previous | ~q;
        end
      end
      PEND: begin
        // The buffered (older) redirect wins; newer decisions are dropped
        if (bus.fetch_ready) begin
          pc_nxt    = pend_target;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // IF/ID boundary registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      pend_target <= 16'h0000;
      vld         <= 1'b0;
      pulse       <= 1'b0;
      cnt         <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_target <= pend_nxt;
      vld         <= vld_nxt;
      pulse       <= pulse_nxt;
      cnt         <= cnt_nxt;
      err         <= err_nxt;
    end
  end

  assign bus.pc_IF          = pc;
  assign bus.Valid1_IF_ID   = vld;
  assign bus.Valid2_IF_ID   = vld;
  assign bus.redirect_taken = pulse;
  assign bus.redirect_count = cnt;
  assign bus.protocol_err   = err;

endmodule
